avalon_stream_buffer: RTL and testbench

- Single-clock Avalon-ST buffer (FIFO) between a stream source and a stream sink.
- Decouples `in_ready` from `out_ready` so there is no combinational path between the two sides.
- Absorbs up to 2^LOG_DEPTH words of sink back-pressure.
- Used as the synthesisable same-clock counterpart of the team's stream clock crossers, wherever a registered stream boundary is required.

---
 rtl/avalon_stream_pkg.sv | 18 +
 rtl/simple_dual_port_regfile.sv | 24 ++
 rtl/avalon_stream_buffer.sv | 71 +++++++
 tb/tb_avalon_stream_buffer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/avalon_stream_pkg.sv
// rtl/avalon_stream_pkg.sv - shared Avalon-ST constants and pointer helper
package avalon_stream_pkg;

   localparam int AVALON_ST_READY_LATENCY = 0;

   // Widest pointer any buffer instance may use (LOG_DEPTH up to 10).
   localparam int PTR_MAX_W = 10;

   function automatic logic [PTR_MAX_W-1:0] ptr_inc(
      input logic [PTR_MAX_W-1:0] ptr,
      input int unsigned          log_depth
   );
      logic [PTR_MAX_W-1:0] mask;
      mask = PTR_MAX_W'((1 << log_depth) - 1);
      return (ptr + 1'b1) & mask;
   endfunction

endpackage

// File: rtl/simple_dual_port_regfile.sv
// rtl/simple_dual_port_regfile.sv - storage with synchronous write and asynchronous read
module simple_dual_port_regfile #(
   parameter int DATA_WIDTH = 8,
   parameter int LOG_DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [LOG_DEPTH-1:0]  wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [LOG_DEPTH-1:0]  rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [0:(1<<LOG_DEPTH)-1];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/avalon_stream_buffer.sv
// rtl/avalon_stream_buffer.sv - single-clock Avalon-ST FIFO with registered ready/valid on both sides
import avalon_stream_pkg::*;

module avalon_stream_buffer #(
   parameter int DATA_WIDTH = 8,
   parameter int LOG_DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   output logic                  in_ready,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [LOG_DEPTH:0]    fill_level
);

   localparam int DEPTH = 1 << LOG_DEPTH;
   localparam logic [LOG_DEPTH:0] DEPTH_CNT = (LOG_DEPTH+1)'(DEPTH);

   logic [LOG_DEPTH-1:0] wr_ptr;
   logic [LOG_DEPTH-1:0] rd_ptr;
   logic [LOG_DEPTH:0]   count;
   logic                 alive;
   logic                 push;
   logic                 pop;

   // Both handshakes come from registered state only, so neither side sees the other combinationally.
   assign in_ready   = alive && (count != DEPTH_CNT);
   assign out_valid  = (count != '0);
   assign fill_level = count;

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         alive  <= 1'b0;
      end else begin
         alive <= 1'b1;
         if (push) begin
            wr_ptr <= LOG_DEPTH'(ptr_inc(PTR_MAX_W'(wr_ptr), LOG_DEPTH));
         end
         if (pop) begin
            rd_ptr <= LOG_DEPTH'(ptr_inc(PTR_MAX_W'(rd_ptr), LOG_DEPTH));
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   simple_dual_port_regfile #(
      .DATA_WIDTH (DATA_WIDTH),
      .LOG_DEPTH  (LOG_DEPTH)
   ) u_storage (
      .clk     (clk),
      .wr_en   (push),
      .wr_addr (wr_ptr),
      .wr_data (in_data),
      .rd_addr (rd_ptr),
      .rd_data (out_data)
   );

endmodule

// File: tb/tb_avalon_stream_buffer.sv
// tb/tb_avalon_stream_buffer.sv - scoreboard bench for avalon_stream_buffer with LOG_DEPTH=2
module tb_avalon_stream_buffer;

   localparam int DW    = 8;
   localparam int LD    = 2;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          in_ready;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          out_ready = 1'b0;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic [LD:0]   fill_level;

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] exp_q[$];
   int            model_count = 0;
   int            model_alive = 0;
   int            pops = 0;
   int            pops_base;

   avalon_stream_buffer #(
      .DATA_WIDTH (DW),
      .LOG_DEPTH  (LD)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_ready   (in_ready),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .fill_level (fill_level)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: at each falling edge, compare outputs with the model, then advance the model
   // to the state the coming rising edge should produce.
   always @(negedge clk) begin
      int acc;
      int pp;
      if (!reset_n) begin
         check("rst_in_ready", int'(in_ready), 0);
         check("rst_out_valid", int'(out_valid), 0);
         check("rst_fill", int'(fill_level), 0);
         model_count = 0;
         model_alive = 0;
         exp_q.delete();
      end else begin
         check("in_ready", int'(in_ready), int'(model_alive != 0 && model_count != DEPTH));
         check("out_valid", int'(out_valid), int'(model_count != 0));
         check("fill_level", int'(fill_level), model_count);
         acc = int'(in_valid && model_alive != 0 && model_count < DEPTH);
         pp  = int'(model_count != 0 && out_ready);
         if (model_count != 0) begin
            if (exp_q.size() == 0) begin
               check("scoreboard_underflow", 1, 0);
            end else begin
               check("out_data", int'(out_data), int'(exp_q[0]));
            end
         end
         if (pp != 0) begin
            void'(exp_q.pop_front());
            pops++;
         end
         if (acc != 0) exp_q.push_back(in_data);
         model_count = model_count + acc - pp;
         model_alive = 1;
      end
   end

   initial begin
      // 1: reset and release
      repeat (2) step();
      check("t1_ready_in_reset", int'(in_ready), 0);
      reset_n = 1'b1;
      #1;
      check("t1_ready_cycle1", int'(in_ready), 0);
      step();
      check("t1_ready_cycle2", int'(in_ready), 1);
      check("t1_out_valid", int'(out_valid), 0);
      check("t1_fill", int'(fill_level), 0);

      // 2: fill to DEPTH, fifth word held off
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = 8'h11 * 8'(i + 1);
         step();
         check("t2_fill_step", int'(fill_level), i + 1);
      end
      check("t2_full_ready", int'(in_ready), 0);
      in_data = 8'h55;
      repeat (2) step();
      check("t2_fifth_rejected", int'(fill_level), 4);
      check("t2_head", int'(out_data), 8'h11);

      // 3: drain in order, 0x55 enters after first pop
      out_ready = 1'b1;
      step();
      check("t3_ready_after_pop", int'(in_ready), 1);
      check("t3_fill_after_pop", int'(fill_level), 3);
      step();
      in_valid = 1'b0;
      check("t3_fill_push_pop", int'(fill_level), 3);
      repeat (4) step();
      check("t3_pops", pops, 5);
      check("t3_empty", int'(fill_level), 0);
      out_ready = 1'b0;
      step();

      // 4: single-word latency through an empty buffer
      pops_base = pops;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'hA5;
      step();
      in_valid = 1'b0;
      check("t4_valid_next", int'(out_valid), 1);
      check("t4_data_next", int'(out_data), 8'hA5);
      step();
      check("t4_fill_zero", int'(fill_level), 0);
      check("t4_popped", pops - pops_base, 1);

      // 5: streaming 3*DEPTH words across pointer wrap
      pops_base = pops;
      in_valid = 1'b1;
      for (int i = 0; i < 3 * DEPTH; i++) begin
         in_data = 8'(i + 8'h80);
         step();
         check("t5_steady_fill", int'(fill_level), 1);
      end
      in_valid = 1'b0;
      step();
      check("t5_pops", pops - pops_base, 3 * DEPTH);
      check("t5_empty", int'(fill_level), 0);
      out_ready = 1'b0;

      // 6: asynchronous reset with words in flight
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 8'h61 + 8'(i);
         step();
      end
      check("t6_fill_before", int'(fill_level), 3);
      reset_n  = 1'b0;
      in_valid = 1'b0;
      #1;
      check("t6_async_fill", int'(fill_level), 0);
      check("t6_async_valid", int'(out_valid), 0);
      step();
      reset_n = 1'b1;
      step();
      pops_base = pops;
      in_valid  = 1'b1;
      in_data   = 8'h77;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      check("t6_first_after_reset", int'(out_data), 8'h77);
      repeat (2) step();
      check("t6_pops", pops - pops_base, 1);
      check("t6_empty", int'(fill_level), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
